clk_div_ctrl: RTL and testbench

- Programmable clock divider with a reconfiguration controller, fed from the 12 MHz board clock.
- Generates a divided clock clk_out (default 12 MHz / 3 = 4 MHz) and a one-cycle tick strobe.
- Two requesters share the single divider; a round-robin arbiter decides who may change the divide ratio.
- The controller sequences every ratio change glitch-free: drain the current period, load the new ratio, settle, then acknowledge.

---
 rtl/clk_div_ctrl.sv | 145 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with arbitrated, glitch-free ratio changes
module clk_div_ctrl #(
    parameter int DIV_W          = 8,
    parameter int DEFAULT_DIV    = 3,
    parameter int SETTLE_PERIODS = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [DIV_W-1:0] div0,
    input  logic [DIV_W-1:0] div1,
    output logic [1:0]       ack,
    output logic             err,
    output logic             clk_out,
    output logic             tick,
    output logic             locked,
    output logic             busy
);

    localparam int SW = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
    localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO         = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_RST     = DIV_W'(DEFAULT_DIV);
    localparam logic [SW-1:0]    SONE        = SW'(1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_PERIODS - 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_LOAD, S_SETTLE} state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] r_n, w_n_nxt;
    logic [DIV_W-1:0] r_pend, w_pend_nxt;
    logic [SW-1:0]    r_settle, w_settle_nxt;
    logic             r_pend_vld, w_pend_vld_nxt;
    logic             r_grant, w_grant_nxt;
    logic             r_ptr, w_ptr_nxt;
    logic [1:0]       r_ack, w_ack_nxt;
    logic             r_err, w_err_nxt;
    logic             r_clk_out, r_tick;
    logic             w_force_low, w_clk_nxt, w_tick_nxt;
    logic             w_wrap, w_gnt;
    logic [DIV_W-1:0] w_gnt_div;

    assign w_wrap    = (r_cnt == r_n - ONE);
    assign w_gnt     = req[r_ptr] ? r_ptr : ~r_ptr;
    assign w_gnt_div = w_gnt ? div1 : div0;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = w_wrap ? '0 : r_cnt + ONE;
        w_n_nxt        = r_n;
        w_pend_nxt     = r_pend;
        w_settle_nxt   = r_settle;
        w_pend_vld_nxt = r_pend_vld;
        w_grant_nxt    = r_grant;
        w_ptr_nxt      = r_ptr;
        w_ack_nxt      = 2'b00;
        w_err_nxt      = 1'b0;
        w_force_low    = 1'b0;
        case (r_state)
            S_RUN: begin
                // no arbitration on the ack cycle, so a held req cannot be granted twice
                if (r_ack == 2'b00 && req != 2'b00) begin
                    w_ptr_nxt = ~w_gnt;
                    if (w_gnt_div < TWO) begin
                        w_ack_nxt = w_gnt ? 2'b10 : 2'b01;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_pend_nxt     = w_gnt_div;
                        w_grant_nxt    = w_gnt;
                        w_pend_vld_nxt = 1'b1;
                        w_state_nxt    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_wrap) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                    w_n_nxt     = r_pend;
                    w_force_low = 1'b1;
                end
            end
            S_LOAD: begin
                w_cnt_nxt    = '0;
                w_settle_nxt = '0;
                w_state_nxt  = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_wrap) begin
                    if (r_settle == SETTLE_LAST) begin
                        w_state_nxt    = S_RUN;
                        w_pend_vld_nxt = 1'b0;
                        if (r_pend_vld) w_ack_nxt = r_grant ? 2'b10 : 2'b01;
                    end else begin
                        w_settle_nxt = r_settle + SONE;
                    end
                end
            end
            default: w_state_nxt = S_SETTLE;
        endcase
    end

    // outputs are computed from the next count so the registered clk_out/tick track r_cnt
    assign w_clk_nxt  = !w_force_low && (w_cnt_nxt < (w_n_nxt >> 1));
    assign w_tick_nxt = !w_force_low && (w_cnt_nxt == w_n_nxt - ONE);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state    <= S_SETTLE;
            r_cnt      <= '0;
            r_n        <= DIV_RST;
            r_pend     <= DIV_RST;
            r_settle   <= '0;
            r_pend_vld <= 1'b0;
            r_grant    <= 1'b0;
            r_ptr      <= 1'b0;
            r_ack      <= 2'b00;
            r_err      <= 1'b0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_n        <= w_n_nxt;
            r_pend     <= w_pend_nxt;
            r_settle   <= w_settle_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_grant    <= w_grant_nxt;
            r_ptr      <= w_ptr_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_clk_out  <= w_clk_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign ack     = r_ack;
    assign err     = r_err;
    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign locked  = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign busy    = (r_state != S_RUN);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - randomized trace-model bench for clk_div_ctrl
`timescale 1ns/1ps
module tb_clk_div_ctrl;

    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 3;
    localparam int SP      = 2;

    logic             clk_in = 1'b0;
    logic             reset  = 1'b1;
    logic [1:0]       req    = 2'b00;
    logic [DIV_W-1:0] div0   = '0;
    logic [DIV_W-1:0] div1   = '0;
    logic [1:0]       ack;
    logic             err, clk_out, tick, locked, busy;

    clk_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF_DIV), .SETTLE_PERIODS(SP)) dut (
        .clk_in(clk_in), .reset(reset), .req(req), .div0(div0), .div1(div1),
        .ack(ack), .err(err), .clk_out(clk_out), .tick(tick), .locked(locked), .busy(busy)
    );

    always #41.667 clk_in = ~clk_in;

    // per-cycle vector: {clk_out, tick, locked, busy, ack[1:0], err}
    typedef logic [6:0] vec_t;
    localparam vec_t RESET_VEC = 7'b0001000;

    int n_checks = 0;
    int n_errors = 0;

    vec_t             exp_q[$];
    vec_t             obs_q[$];
    logic [1:0]       s_req[$];
    logic [DIV_W-1:0] s_d0[$];
    logic [DIV_W-1:0] s_d1[$];
    logic [1:0]       cur_req = 2'b00;
    logic [DIV_W-1:0] cur_d0 = '0;
    logic [DIV_W-1:0] cur_d1 = '0;
    int               m_n, m_ph, m_ptr, m_load_idx;

    // expected behaviour as a cycle trace: each call appends what the block should show
    function automatic void m_push(bit c, bit t, bit l, bit b, logic [1:0] a, bit e);
        exp_q.push_back({c, t, l, b, a, e});
        s_req.push_back(cur_req);
        s_d0.push_back(cur_d0);
        s_d1.push_back(cur_d1);
    endfunction

    function automatic void m_adv(int cyc, bit l, bit b);
        for (int i = 0; i < cyc; i++) begin
            m_ph = (m_ph + 1) % m_n;
            m_push(m_ph < m_n / 2, m_ph == m_n - 1, l, b, 2'b00, 1'b0);
        end
    endfunction

    function automatic void m_reset();
        exp_q.delete(); s_req.delete(); s_d0.delete(); s_d1.delete();
        m_n = DEF_DIV; m_ph = 0; m_ptr = 0;
        m_push(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        m_adv(SP * m_n - 1, 1'b0, 1'b1);
    endfunction

    // the last pushed cycle is the RUN cycle in which requester g was granted divisor d
    function automatic void m_grant(int g, int d);
        logic [1:0] a;
        a = (g == 1) ? 2'b10 : 2'b01;
        m_ptr = 1 - g;
        if (d < 2) begin
            m_ph = (m_ph + 1) % m_n;
            m_push(m_ph < m_n / 2, m_ph == m_n - 1, 1'b1, 1'b0, a, 1'b1);
        end else begin
            do begin
                m_ph = (m_ph + 1) % m_n;
                m_push(m_ph < m_n / 2, m_ph == m_n - 1, 1'b1, 1'b1, 2'b00, 1'b0);
            end while (m_ph != m_n - 1);
            m_load_idx = exp_q.size();
            m_push(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
            m_n  = d;
            m_ph = d - 1;
            m_adv(SP * m_n, 1'b0, 1'b1);
            m_ph = (m_ph + 1) % m_n;
            m_push(m_ph < m_n / 2, m_ph == m_n - 1, 1'b1, 1'b0, a, 1'b0);
        end
        cur_req[g] = 1'b0;
    endfunction

    function automatic void m_request(int g, int d);
        cur_req[g] = 1'b1;
        if (g == 1) cur_d1 = DIV_W'(d); else cur_d0 = DIV_W'(d);
        m_adv(1, 1'b1, 1'b0);
        m_grant(g, d);
    endfunction

    function automatic void m_both(int d0, int d1);
        int w;
        cur_req = 2'b11;
        cur_d0  = DIV_W'(d0);
        cur_d1  = DIV_W'(d1);
        m_adv(1, 1'b1, 1'b0);
        w = m_ptr;
        m_grant(w, (w == 1) ? d1 : d0);
        m_adv(1, 1'b1, 1'b0);
        m_grant(1 - w, (w == 1) ? d0 : d1);
    endfunction

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    task automatic run_capture(int n);
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i == 0) #1;
            else begin
                @(posedge clk_in);
                #1;
            end
            obs_q.push_back({clk_out, tick, locked, busy, ack, err});
            if (i < s_req.size()) begin
                req  = s_req[i];
                div0 = s_d0[i];
                div1 = s_d1[i];
            end
        end
    endtask

    task automatic test_reset();
        #100;
        n_checks++;
        if ({clk_out, tick, locked, busy, ack, err} !== RESET_VEC) begin
            n_errors++;
            $display("FAIL reset_hold: got %b required %b", {clk_out, tick, locked, busy, ack, err}, RESET_VEC);
        end
        #66;
        reset   = 1'b0;
        cur_req = 2'b00;
        m_reset();
        m_adv(12, 1'b1, 1'b0);
        run_capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL reset_release cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_change();
        do_reset();
        cur_req = 2'b00;
        m_reset();
        m_adv($urandom_range(1, 5), 1'b1, 1'b0);
        m_request(0, 6);
        m_adv(8, 1'b1, 1'b0);
        run_capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL change_to_6 cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_both();
        do_reset();
        cur_req = 2'b00;
        m_reset();
        m_both(4, 5);
        m_adv(12, 1'b1, 1'b0);
        run_capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL both_requests cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_invalid();
        do_reset();
        cur_req = 2'b00;
        m_reset();
        m_adv($urandom_range(1, 4), 1'b1, 1'b0);
        m_request(1, $urandom_range(0, 1));
        m_adv(6, 1'b1, 1'b0);
        run_capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL invalid_div cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        cur_req = 2'b00;
        m_reset();
        m_adv(2, 1'b1, 1'b0);
        m_request(0, 8);
        k = m_load_idx + int'($urandom_range(1, 2 * 8));
        run_capture(k + 1);
        for (int i = 0; i <= k; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL pre_abort cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
        #10;
        reset = 1'b1;
        req   = 2'b00;
        #1;
        n_checks++;
        if ({clk_out, tick, locked, busy, ack, err} !== RESET_VEC) begin
            n_errors++;
            $display("FAIL async_abort: got %b required %b", {clk_out, tick, locked, busy, ack, err}, RESET_VEC);
        end
        @(negedge clk_in);
        @(negedge clk_in);
        reset   = 1'b0;
        cur_req = 2'b00;
        m_reset();
        m_adv(9, 1'b1, 1'b0);
        run_capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL post_abort cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_long_run();
        int start, ticks, hi_len;
        bit seen_rise;
        do_reset();
        cur_req = 2'b00;
        m_reset();
        m_adv(2, 1'b1, 1'b0);
        m_request(0, 5);
        start = exp_q.size();
        m_adv(1000, 1'b1, 1'b0);
        run_capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL run_n5 cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
        ticks = 0; hi_len = 0; seen_rise = 1'b0;
        for (int i = start; i < start + 1000; i++) begin
            if (obs_q[i][5]) ticks++;
            if (obs_q[i][6]) begin
                if (i > start && !obs_q[i-1][6]) seen_rise = 1'b1;
                hi_len++;
            end else begin
                if (seen_rise) begin
                    n_checks++;
                    if (hi_len != 2) begin
                        n_errors++;
                        $display("FAIL high_width cycle %0d: got %0d required 2", i, hi_len);
                    end
                end
                hi_len = 0;
                seen_rise = 1'b0;
            end
        end
        n_checks++;
        if (ticks != 200) begin
            n_errors++;
            $display("FAIL tick_count: got %0d required 200", ticks);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        cur_req = 2'b00;
        m_reset();
        m_adv(1, 1'b1, 1'b0);
        m_request(1, 2);
        m_adv(4, 1'b1, 1'b0);
        m_request(0, 255);
        m_adv(260, 1'b1, 1'b0);
        run_capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL boundary_div cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cur_req = 2'b00;
        m_reset();
        m_adv(1, 1'b1, 1'b0);
        for (int op = 0; op < 8; op++) begin
            m_adv($urandom_range(0, 4), 1'b1, 1'b0);
            if ($urandom_range(0, 2) == 0)
                m_both($urandom_range(0, 9), $urandom_range(0, 9));
            else
                m_request($urandom_range(0, 1), $urandom_range(0, 9));
        end
        m_adv(10, 1'b1, 1'b0);
        run_capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL back_to_back cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_change();
        test_both();
        test_invalid();
        test_reset_mid();
        test_long_run();
        test_boundary();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
